// File: rtl/sp_frame_tx.sv
// Transmit framer: buffers payload bytes, then emits SYNC, escaped count, escaped body
// and an optional SP_END tail (enabled by `define SPFRAME_TAIL_EN) into the uart TX path.
module sp_frame_tx #(
    parameter int          DATAMAXBYTES = 10,
    parameter logic [7:0]  SP_SYNC      = 8'b01111110,
    parameter logic [7:0]  SP_ESC       = 8'b00000010,
    parameter logic [7:0]  SP_END       = 8'b00000011
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    output logic       wr_err,
    input  logic       send,
    output logic       busy,
    output logic       frame_done,
    output logic [7:0] buf_count,
    output logic [7:0] tx_data,
    output logic       ld_tx_data,
    input  logic       tx_empty
);

    localparam int AW    = (DATAMAXBYTES > 1) ? $clog2(DATAMAXBYTES) : 1;
    localparam int DEPTH = 2 ** AW;
    localparam logic [7:0] MAXCOUNT = 8'(DATAMAXBYTES);

    typedef enum logic [2:0] {IDLE, SYNC, BCNT, BODY, TAIL, DONE} state_t;

    state_t     state, stateNext;
    logic [7:0] payload [DEPTH];
    logic [7:0] bufCount, bufCountNext;
    logic [7:0] frameLen, frameLenNext;
    logic [7:0] idx, idxNext;
    logic [7:0] txData, txDataNext;
    logic       ldTx, ldTxNext;
    logic       gap, gapNext;
    logic       escSent, escSentNext;
    logic       busyR, busyNext;
    logic       wrErr, wrErrNext;
    logic       frameDone, frameDoneNext;
    logic       wrAccept;
    logic       escNeeded;
    logic [7:0] curByte;
    state_t     afterBody;

`ifdef SPFRAME_TAIL_EN
    assign afterBody = TAIL;
`else
    assign afterBody = DONE;
`endif

    always_comb begin
        stateNext     = state;
        bufCountNext  = bufCount;
        frameLenNext  = frameLen;
        idxNext       = idx;
        txDataNext    = txData;
        ldTxNext      = 1'b0;
        gapNext       = gap;
        escSentNext   = escSent;
        busyNext      = busyR;
        frameDoneNext = 1'b0;
        curByte       = 8'h00;

        // Writes only land while idle; anything else is reported one cycle later.
        wrAccept  = wr_en && (state == IDLE) && (bufCount != MAXCOUNT);
        wrErrNext = wr_en && !wrAccept;
        if (wrAccept) begin
            bufCountNext = bufCount + 8'd1;
        end

        case (state)
            SYNC:    curByte = SP_SYNC;
            BCNT:    curByte = frameLen;
            BODY:    curByte = payload[idx[AW-1:0]];
            TAIL:    curByte = SP_END;
            default: curByte = 8'h00;
        endcase
        escNeeded = ((state == BCNT) || (state == BODY)) && !escSent &&
                    ((curByte == SP_SYNC) || (curByte == SP_ESC));

        case (state)
            IDLE: begin
                if (send) begin
                    frameLenNext = bufCount + {7'd0, wrAccept};
                    idxNext      = 8'd0;
                    escSentNext  = 1'b0;
                    gapNext      = 1'b0;
                    busyNext     = 1'b1;
                    stateNext    = SYNC;
                end
            end
            SYNC, BCNT, BODY, TAIL: begin
                if (ldTx) begin
                    // Load cycle: decide the next byte while the uart latches this one.
                    gapNext = 1'b1;
                    if (escNeeded) begin
                        escSentNext = 1'b1;
                    end else begin
                        escSentNext = 1'b0;
                        case (state)
                            SYNC: stateNext = BCNT;
                            BCNT: stateNext = (frameLen == 8'd0) ? afterBody : BODY;
                            BODY: begin
                                if (idx == frameLen - 8'd1) begin
                                    stateNext = afterBody;
                                end else begin
                                    idxNext = idx + 8'd1;
                                end
                            end
                            default: stateNext = DONE;
                        endcase
                    end
                end else if (gap) begin
                    gapNext = 1'b0;
                end else if (tx_empty) begin
                    ldTxNext   = 1'b1;
                    txDataNext = escNeeded ? SP_ESC : curByte;
                end
            end
            DONE: begin
                frameDoneNext = 1'b1;
                busyNext      = 1'b0;
                bufCountNext  = 8'd0;
                stateNext     = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            bufCount  <= 8'd0;
            frameLen  <= 8'd0;
            idx       <= 8'd0;
            txData    <= 8'd0;
            ldTx      <= 1'b0;
            gap       <= 1'b0;
            escSent   <= 1'b0;
            busyR     <= 1'b0;
            wrErr     <= 1'b0;
            frameDone <= 1'b0;
        end else begin
            state     <= stateNext;
            bufCount  <= bufCountNext;
            frameLen  <= frameLenNext;
            idx       <= idxNext;
            txData    <= txDataNext;
            ldTx      <= ldTxNext;
            gap       <= gapNext;
            escSent   <= escSentNext;
            busyR     <= busyNext;
            wrErr     <= wrErrNext;
            frameDone <= frameDoneNext;
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                payload[k] <= 8'd0;
            end
        end else if (wrAccept) begin
            payload[bufCount[AW-1:0]] <= wr_data;
        end
    end

    assign wr_err     = wrErr;
    assign busy       = busyR;
    assign frame_done = frameDone;
    assign buf_count  = bufCount;
    assign tx_data    = txData;
    assign ld_tx_data = ldTx;

endmodule

// File: tb/tb_sp_frame_tx.sv
// Bench for sp_frame_tx: uart TX model plus a queue-based frame reference.
module tb_sp_frame_tx;

    localparam int MAXB = 10;

    logic       CLK = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       wr_err;
    logic       send;
    logic       busy;
    logic       frame_done;
    logic [7:0] buf_count;
    logic [7:0] tx_data;
    logic       ld_tx_data;
    logic       tx_empty;
    logic       txEmptyModel;
    logic       holdLow;

    logic [7:0] got[$];
    logic [7:0] pend[$];
    int nChecks = 0;
    int nPass   = 0;

    always #5 CLK = ~CLK;

    assign tx_empty = txEmptyModel && !holdLow;

    sp_frame_tx dut (
        .CLK(CLK), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .wr_err(wr_err),
        .send(send), .busy(busy), .frame_done(frame_done), .buf_count(buf_count),
        .tx_data(tx_data), .ld_tx_data(ld_tx_data), .tx_empty(tx_empty)
    );

    // uart model: flag drops one cycle after a load and returns ten cycles later
    initial begin
        int cnt;
        bit dropPending;
        cnt = 0;
        dropPending = 0;
        txEmptyModel = 1'b1;
        forever begin
            @(negedge CLK);
            if (dropPending) begin
                txEmptyModel = 1'b0;
                cnt = 10;
                dropPending = 0;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) txEmptyModel = 1'b1;
            end
            if (ld_tx_data === 1'b1) begin
                got.push_back(tx_data);
                dropPending = 1;
            end
        end
    end

    function automatic void pushEsc(inout logic [7:0] q[$], input logic [7:0] b);
        if (b == 8'h7E || b == 8'h02) q.push_back(8'h02);
        q.push_back(b);
    endfunction

    function automatic void buildFrame(input logic [7:0] pl[$], output logic [7:0] fr[$]);
        fr = {};
        fr.push_back(8'h7E);
        pushEsc(fr, 8'(pl.size()));
        foreach (pl[k]) pushEsc(fr, pl[k]);
`ifdef SPFRAME_TAIL_EN
        fr.push_back(8'h03);
`endif
    endfunction

    task automatic writeByte(input logic [7:0] b, input logic expErr);
        @(negedge CLK);
        wr_en = 1'b1;
        wr_data = b;
        @(negedge CLK);
        wr_en = 1'b0;
        nChecks++;
        if (wr_err !== expErr)
            $display("FAIL wr_err byte %02h: got %b want %b", b, wr_err, expErr);
        else nPass++;
        if (!expErr) pend.push_back(b);
    endtask

    task automatic waitDone(input string name);
        int done, cyc, extra;
        logic [7:0] exp[$];
        done = 0; cyc = 0; extra = 0;
        while (done == 0 && cyc < 3000) begin
            @(negedge CLK);
            cyc++;
            if (frame_done === 1'b1) done++;
        end
        repeat (5) begin
            @(negedge CLK);
            if (frame_done === 1'b1) extra++;
        end
        nChecks++;
        if (done + extra != 1)
            $display("FAIL %s frame_done pulses: got %0d want 1", name, done + extra);
        else nPass++;
        nChecks++;
        if (buf_count !== 8'd0 || busy !== 1'b0)
            $display("FAIL %s after done: buf_count %0d busy %b want 0 0", name, buf_count, busy);
        else nPass++;
        buildFrame(pend, exp);
        nChecks++;
        if (got.size() != exp.size())
            $display("FAIL %s frame length: got %0d want %0d", name, got.size(), exp.size());
        else nPass++;
        for (int k = 0; k < exp.size() && k < got.size(); k++) begin
            nChecks++;
            if (got[k] !== exp[k])
                $display("FAIL %s byte %0d: got %02h want %02h", name, k, got[k], exp[k]);
            else nPass++;
        end
        pend.delete();
    endtask

    task automatic sendFrame(input string name, input bit withWrite, input logic [7:0] b);
        got.delete();
        @(negedge CLK);
        send = 1'b1;
        if (withWrite) begin
            wr_en = 1'b1;
            wr_data = b;
            pend.push_back(b);
        end
        @(negedge CLK);
        send = 1'b0;
        wr_en = 1'b0;
        nChecks++;
        if (busy !== 1'b1) $display("FAIL %s busy after send: got %b want 1", name, busy);
        else nPass++;
        waitDone(name);
    endtask

    task automatic waitBytes(input int n, input string name);
        int cyc;
        cyc = 0;
        while (got.size() < n && cyc < 2000) begin
            @(negedge CLK);
            #1;
            cyc++;
        end
        nChecks++;
        if (got.size() < n) $display("FAIL %s wait timeout: got %0d bytes want %0d", name, got.size(), n);
        else nPass++;
    endtask

    task automatic test_reset();
        reset = 1'b1; wr_en = 1'b0; wr_data = 8'h00; send = 1'b0; holdLow = 1'b0;
        repeat (3) @(negedge CLK);
        reset = 1'b0;
        @(negedge CLK);
        nChecks++;
        if ({busy, ld_tx_data, wr_err, frame_done} !== 4'b0000)
            $display("FAIL reset flags: got %b want 0000", {busy, ld_tx_data, wr_err, frame_done});
        else nPass++;
        nChecks++;
        if (buf_count !== 8'd0 || tx_data !== 8'd0)
            $display("FAIL reset data: buf_count %02h tx_data %02h want 00 00", buf_count, tx_data);
        else nPass++;
    endtask

    task automatic test_basic();
        writeByte(8'h11, 0); writeByte(8'h22, 0); writeByte(8'h33, 0);
        sendFrame("basic", 0, 8'h00);
        writeByte(8'h7E, 0); writeByte(8'h41, 0);
        sendFrame("escape", 0, 8'h00);
    endtask

    task automatic test_overflow();
        for (int k = 0; k < MAXB; k++) writeByte(8'(k), 0);
        nChecks++;
        if (buf_count !== 8'(MAXB)) $display("FAIL full count: got %0d want %0d", buf_count, MAXB);
        else nPass++;
        writeByte(8'h0A, 1);
        nChecks++;
        if (buf_count !== 8'(MAXB)) $display("FAIL count after drop: got %0d want %0d", buf_count, MAXB);
        else nPass++;
        sendFrame("overflow", 0, 8'h00);
    endtask

    task automatic test_empty();
        sendFrame("empty", 0, 8'h00);
    endtask

    task automatic test_same_cycle();
        writeByte(8'h02, 0); writeByte(8'h5A, 0);
        sendFrame("wr_send_same", 1, 8'h7E);
    endtask

    task automatic test_stall();
        logic [7:0] held;
        int bad;
        writeByte(8'h55, 0); writeByte(8'h66, 0); writeByte(8'h77, 0); writeByte(8'h88, 0);
        got.delete();
        @(negedge CLK); send = 1'b1;
        @(negedge CLK); send = 1'b0;
        waitBytes(3, "stall");
        holdLow = 1'b1;
        held = tx_data;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK);
            if (ld_tx_data !== 1'b0 || tx_data !== held) bad++;
            send = (k == 5);
            wr_en = (k == 10);
            wr_data = 8'h99;
            if (k == 11) begin
                nChecks++;
                if (wr_err !== 1'b1) $display("FAIL busy write wr_err: got %b want 1", wr_err);
                else nPass++;
            end
        end
        send = 1'b0; wr_en = 1'b0;
        nChecks++;
        if (bad != 0 || got.size() != 3)
            $display("FAIL stall hold: %0d violations, %0d bytes, want 0 and 3", bad, got.size());
        else nPass++;
        holdLow = 1'b0;
        waitDone("stall");
    endtask

    task automatic test_reset_mid();
        writeByte(8'hA1, 0); writeByte(8'hA2, 0); writeByte(8'hA3, 0);
        got.delete();
        @(negedge CLK); send = 1'b1;
        @(negedge CLK); send = 1'b0;
        waitBytes(2, "reset_mid");
        reset = 1'b1;
        #1;
        nChecks++;
        if (ld_tx_data !== 1'b0 || busy !== 1'b0 || buf_count !== 8'd0)
            $display("FAIL reset_mid: ld %b busy %b buf_count %0d want 0 0 0", ld_tx_data, busy, buf_count);
        else nPass++;
        @(negedge CLK);
        reset = 1'b0;
        pend.delete();
        repeat (60) @(negedge CLK);
        nChecks++;
        if (got.size() != 2 || busy !== 1'b0)
            $display("FAIL reset_mid after: %0d bytes busy %b want 2 0", got.size(), busy);
        else nPass++;
    endtask

    task automatic test_random();
        for (int f = 0; f < 6; f++) begin
            int len;
            len = $urandom_range(0, MAXB);
            for (int k = 0; k < len; k++) begin
                int r;
                logic [7:0] b;
                r = $urandom_range(0, 3);
                b = (r == 0) ? 8'h7E : (r == 1) ? 8'h02 : 8'($urandom);
                writeByte(b, 0);
            end
            sendFrame("random", 0, 8'h00);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_empty();
        test_same_cycle();
        test_stall();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
